// File: rtl/layer_compositor.sv
// N-layer raster compositor: raster address issue, priority/colour-key merge, FWFT output FIFO.
// Optional background colour port enabled by defining LAYER_COMPOSITOR_BG_EN.
module layer_compositor #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int NUM_LAYERS   = 5,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int COLOR_WIDTH  = 12,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '1,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NUM_LAYERS-1:0]             layer_visible,
`ifdef LAYER_COMPOSITOR_BG_EN
    input  logic [COLOR_WIDTH-1:0]            bg_color,
`endif
    output logic                              rd_en,
    output logic [XW-1:0]                     rd_x,
    output logic [YW-1:0]                     rd_y,
    input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COLOR_WIDTH-1:0]            out_color,
    output logic [XW-1:0]                     out_x,
    output logic [YW-1:0]                     out_y,
    output logic                              out_sof,
    output logic                              out_eol,
    output logic                              frame_done
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int IW   = $clog2(READ_LATENCY + 1);

    typedef struct packed {
        logic [XW-1:0]         x;
        logic [YW-1:0]         y;
        logic                  sof;
        logic                  eol;
        logic [NUM_LAYERS-1:0] mask;
`ifdef LAYER_COMPOSITOR_BG_EN
        logic [COLOR_WIDTH-1:0] bg;
`endif
    } tag_t;

    typedef struct packed {
        logic [COLOR_WIDTH-1:0] color;
        logic [XW-1:0]          x;
        logic [YW-1:0]          y;
        logic                   sof;
        logic                   eol;
    } pix_t;

    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [NUM_LAYERS-1:0]  r_mask;
`ifdef LAYER_COMPOSITOR_BG_EN
    logic [COLOR_WIDTH-1:0] r_bg;
`endif
    logic [READ_LATENCY-1:0] r_vld_pipe;
    tag_t                    r_tag [READ_LATENCY];
    logic [IW-1:0]           r_inflight;
    pix_t                    r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CNTW-1:0]         r_count;
    logic                    r_frame_done;

    logic                   w_first;
    logic                   w_last_x;
    logic                   w_last_y;
    logic                   w_push;
    logic                   w_pop;
    int                     w_used;
    tag_t                   w_tag;
    tag_t                   w_head;
    logic [COLOR_WIDTH-1:0] w_color;
    pix_t                   w_pix;
    pix_t                   w_out;

    assign w_first  = (r_x == '0) && (r_y == '0);
    assign w_last_x = (r_x == XW'(WIDTH - 1));
    assign w_last_y = (r_y == YW'(HEIGHT - 1));

    // A pop frees its slot in the same cycle, so issue can resume without a bubble.
    assign w_pop  = out_valid && out_ready;
    assign w_used = int'(r_inflight) + int'(r_count) - int'(w_pop);
    assign rd_en  = !reset && enable && (w_used < FIFO_DEPTH);
    assign rd_x   = r_x;
    assign rd_y   = r_y;

    // The mask rides with each pixel so end-of-frame reads still in flight keep the old mask.
    always_comb begin
        w_tag      = '0;
        w_tag.x    = r_x;
        w_tag.y    = r_y;
        w_tag.sof  = w_first;
        w_tag.eol  = w_last_x;
        w_tag.mask = w_first ? layer_visible : r_mask;
`ifdef LAYER_COMPOSITOR_BG_EN
        w_tag.bg   = w_first ? bg_color : r_bg;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_mask     <= '0;
`ifdef LAYER_COMPOSITOR_BG_EN
            r_bg       <= '0;
`endif
            r_vld_pipe <= '0;
            r_inflight <= '0;
        end else begin
            if (rd_en) begin
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= w_last_y ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_first) begin
                    r_mask <= layer_visible;
`ifdef LAYER_COMPOSITOR_BG_EN
                    r_bg   <= bg_color;
`endif
                end
            end
            r_vld_pipe[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_inflight <= r_inflight + IW'(rd_en) - IW'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        r_tag[0] <= w_tag;
        for (int i = 1; i < READ_LATENCY; i++)
            r_tag[i] <= r_tag[i-1];
    end

    assign w_push = r_vld_pipe[READ_LATENCY-1];
    assign w_head = r_tag[READ_LATENCY-1];

    // Ascending scan: the highest visible non-transparent layer is written last and wins.
    always_comb begin
        w_color = layer_data[0 +: COLOR_WIDTH];
`ifdef LAYER_COMPOSITOR_BG_EN
        if (!w_head.mask[0] || (w_color == COLOR_NONE))
            w_color = w_head.bg;
`endif
        for (int i = 1; i < NUM_LAYERS; i++) begin
            if (w_head.mask[i] && (layer_data[i*COLOR_WIDTH +: COLOR_WIDTH] != COLOR_NONE))
                w_color = layer_data[i*COLOR_WIDTH +: COLOR_WIDTH];
        end
    end

`ifndef LAYER_COMPOSITOR_BG_EN
    logic w_unused;
    assign w_unused = w_head.mask[0];
`endif

    always_comb begin
        w_pix       = '0;
        w_pix.color = w_color;
        w_pix.x     = w_head.x;
        w_pix.y     = w_head.y;
        w_pix.sof   = w_head.sof;
        w_pix.eol   = w_head.eol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_pix;
                r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_count      <= r_count + CNTW'(w_push) - CNTW'(w_pop);
            r_frame_done <= w_pop && (w_out.x == XW'(WIDTH - 1)) && (w_out.y == YW'(HEIGHT - 1));
        end
    end

    assign w_out      = r_mem[r_rptr];
    assign out_valid  = (r_count != '0);
    assign out_color  = w_out.color;
    assign out_x      = w_out.x;
    assign out_y      = w_out.y;
    assign out_sof    = w_out.sof;
    assign out_eol    = w_out.eol;
    assign frame_done = r_frame_done;

endmodule
